// File: rtl/audio_volume_ctrl.sv
// Volume/mute sequencer: turns debounced vol+/vol- buttons and CPU writes into a
// saturating volume level plus mute flag, offered to the gain stage via req/ack.
module audio_volume_ctrl #(
    parameter int unsigned VOL_W         = 5,
    parameter int unsigned VOL_MAX       = 31,
    parameter int unsigned VOL_DEFAULT   = 24,
    parameter int unsigned HOLD_CYCLES   = 12500000,
    parameter int unsigned REPEAT_CYCLES = 2500000,
    parameter bit          BTN_ACT_LOW   = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_btn_up,
    input  logic             i_btn_dn,
    input  logic             i_set_valid,
    input  logic [VOL_W-1:0] i_set_vol,
    output logic [VOL_W-1:0] o_vol,
    output logic             o_mute,
    output logic             o_upd,
    input  logic             i_ack,
    output logic [1:0]       o_state
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [VOL_W-1:0] V_MAX     = VOL_W'(VOL_MAX);
    localparam logic [VOL_W-1:0] V_DEF     = VOL_W'(VOL_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2,
        ST_COMBO  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir_up;
    logic             r_up_q;
    logic             r_dn_q;
    logic [VOL_W-1:0] r_vol;
    logic             r_mute;
    logic             r_upd;

    state_t           w_state_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_dir_up_n;
    logic             w_up;
    logic             w_dn;
    logic             w_up_edge;
    logic             w_dn_edge;
    logic             w_held;
    logic             w_other;
    logic [CNT_W-1:0] w_last;
    logic             w_step_up;
    logic             w_step_dn;
    logic             w_toggle;
    logic [VOL_W-1:0] w_vol_n;
    logic             w_mute_n;
    logic             w_changed;
    logic             w_upd_n;

    assign w_up      = BTN_ACT_LOW ? ~i_btn_up : i_btn_up;
    assign w_dn      = BTN_ACT_LOW ? ~i_btn_dn : i_btn_dn;
    assign w_up_edge = w_up & ~r_up_q;
    assign w_dn_edge = w_dn & ~r_dn_q;
    assign w_held    = r_dir_up ? w_up : w_dn;
    assign w_other   = r_dir_up ? w_dn : w_up;
    assign w_last    = (r_state == ST_HOLD) ? HOLD_LAST : REP_LAST;

    // State register; edge history resets to "asserted" so a held button needs a fresh press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_dir_up <= 1'b0;
            r_up_q   <= 1'b1;
            r_dn_q   <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_dir_up <= w_dir_up_n;
            r_up_q   <= w_up;
            r_dn_q   <= w_dn;
        end
    end

    // Next-state and step/toggle decisions.
    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_dir_up_n = r_dir_up;
        w_step_up  = 1'b0;
        w_step_dn  = 1'b0;
        w_toggle   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_up && w_dn && (w_up_edge || w_dn_edge)) begin
                    w_toggle  = 1'b1;
                    w_state_n = ST_COMBO;
                end else if (w_up_edge && !w_dn) begin
                    w_step_up  = 1'b1;
                    w_dir_up_n = 1'b1;
                    w_cnt_n    = '0;
                    w_state_n  = ST_HOLD;
                end else if (w_dn_edge && !w_up) begin
                    w_step_dn  = 1'b1;
                    w_dir_up_n = 1'b0;
                    w_cnt_n    = '0;
                    w_state_n  = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!w_held) begin
                    w_state_n = ST_IDLE;
                end else if (w_other) begin
                    w_toggle  = 1'b1;
                    w_state_n = ST_COMBO;
                end else if (r_cnt == w_last) begin
                    w_step_up = r_dir_up;
                    w_step_dn = ~r_dir_up;
                    w_cnt_n   = '0;
                    w_state_n = ST_REPEAT;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end
            ST_COMBO: begin
                if (!w_up && !w_dn) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Value update; a CPU write overrides any button action in the same cycle.
    always_comb begin
        w_vol_n  = r_vol;
        w_mute_n = r_mute;
        if (i_set_valid) begin
            w_vol_n = (i_set_vol > V_MAX) ? V_MAX : i_set_vol;
        end else if (w_step_up) begin
            if (r_vol != V_MAX) begin
                w_vol_n = r_vol + VOL_W'(1);
            end
            w_mute_n = 1'b0;
        end else if (w_step_dn) begin
            if (r_vol != '0) begin
                w_vol_n = r_vol - VOL_W'(1);
            end
            w_mute_n = 1'b0;
        end else if (w_toggle) begin
            w_mute_n = ~r_mute;
        end
    end

    assign w_changed = (w_vol_n != r_vol) || (w_mute_n != r_mute);

    always_comb begin
        w_upd_n = r_upd;
        if (w_changed) begin
            w_upd_n = 1'b1;
        end else if (r_upd && i_ack) begin
            w_upd_n = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vol  <= V_DEF;
            r_mute <= 1'b0;
            r_upd  <= 1'b1;
        end else begin
            r_vol  <= w_vol_n;
            r_mute <= w_mute_n;
            r_upd  <= w_upd_n;
        end
    end

    assign o_vol   = r_vol;
    assign o_mute  = r_mute;
    assign o_upd   = r_upd;
    assign o_state = r_state;

endmodule

// File: tb/tb_audio_volume_ctrl.sv
// Bench for audio_volume_ctrl: directed scenarios plus random button/CPU/ack traffic,
// all checked every cycle against a press-duration based reference model.
module tb_audio_volume_ctrl;

    localparam int unsigned VOL_W  = 6;
    localparam int          HOLD   = 8;
    localparam int          REPEAT = 4;
    localparam int          VMAX   = 31;
    localparam int          VDEF   = 24;

    logic             i_clk       = 1'b0;
    logic             i_rst       = 1'b1;
    logic             i_btn_up    = 1'b0;
    logic             i_btn_dn    = 1'b0;
    logic             i_set_valid = 1'b0;
    logic [VOL_W-1:0] i_set_vol   = '0;
    logic             i_ack       = 1'b0;
    logic [VOL_W-1:0] o_vol;
    logic             o_mute;
    logic             o_upd;
    logic [1:0]       o_state;

    int checks = 0;
    int errors = 0;

    audio_volume_ctrl #(
        .VOL_W(VOL_W), .VOL_MAX(VMAX), .VOL_DEFAULT(VDEF),
        .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REPEAT), .BTN_ACT_LOW(1'b0)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_btn_up(i_btn_up), .i_btn_dn(i_btn_dn),
        .i_set_valid(i_set_valid), .i_set_vol(i_set_vol),
        .o_vol(o_vol), .o_mute(o_mute), .o_upd(o_upd), .i_ack(i_ack), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: mode 0 idle, 1 button pressed, 2 both-button combo.
    // m_k = cycles since the press edge; steps fall at k = 0, HOLD, HOLD+REPEAT, ...
    int m_vol  = VDEF;
    bit m_mute = 1'b0;
    bit m_upd  = 1'b1;
    int m_mode = 0;
    bit m_dir  = 1'b0;
    int m_k    = 0;
    bit m_up_p = 1'b1;
    bit m_dn_p = 1'b1;

    function automatic int exp_state();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 3;
        return (m_k < HOLD) ? 1 : 2;
    endfunction

    task automatic model_reset();
        m_vol = VDEF; m_mute = 1'b0; m_upd = 1'b1;
        m_mode = 0; m_k = 0; m_up_p = 1'b1; m_dn_p = 1'b1;
    endtask

    task automatic model_step();
        bit up, dn, eu, ed, held, other, tog, nm;
        int step, nv;
        up = i_btn_up; dn = i_btn_dn;
        eu = up && !m_up_p; ed = dn && !m_dn_p;
        step = 0; tog = 1'b0;
        case (m_mode)
            0: begin
                if (up && dn && (eu || ed)) begin tog = 1'b1; m_mode = 2; end
                else if (eu && !dn) begin step = 1;  m_dir = 1'b1; m_k = 0; m_mode = 1; end
                else if (ed && !up) begin step = -1; m_dir = 1'b0; m_k = 0; m_mode = 1; end
            end
            1: begin
                held  = m_dir ? up : dn;
                other = m_dir ? dn : up;
                if (!held) m_mode = 0;
                else if (other) begin tog = 1'b1; m_mode = 2; end
                else begin
                    m_k++;
                    if (m_k == HOLD || (m_k > HOLD && (m_k - HOLD) % REPEAT == 0))
                        step = m_dir ? 1 : -1;
                end
            end
            default: if (!up && !dn) m_mode = 0;
        endcase
        nv = m_vol; nm = m_mute;
        if (i_set_valid) nv = (int'(i_set_vol) > VMAX) ? VMAX : int'(i_set_vol);
        else if (step == 1)  begin nv = (m_vol < VMAX) ? m_vol + 1 : VMAX; nm = 1'b0; end
        else if (step == -1) begin nv = (m_vol > 0) ? m_vol - 1 : 0; nm = 1'b0; end
        else if (tog) nm = !m_mute;
        if (nv != m_vol || nm != m_mute) m_upd = 1'b1;
        else if (m_upd && i_ack) m_upd = 1'b0;
        m_vol = nv; m_mute = nm; m_up_p = up; m_dn_p = dn;
    endtask

    initial begin
        forever begin
            @(posedge i_clk or posedge i_rst);
            if (i_rst) model_reset();
            else model_step();
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge i_clk) begin
        cmp("vol",   int'(o_vol),   m_vol);
        cmp("mute",  int'(o_mute),  int'(m_mute));
        cmp("upd",   int'(o_upd),   int'(m_upd));
        cmp("state", int'(o_state), exp_state());
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic cpu_set(input int v);
        i_set_valid = 1'b1; i_set_vol = VOL_W'(v);
        cyc(1);
        i_set_valid = 1'b0;
        i_ack = 1'b1; cyc(1); i_ack = 1'b0;
    endtask

    initial begin
        // 1: reset and first ack
        cyc(3);
        cmp("rst_vol", int'(o_vol), 24);
        cmp("rst_upd", int'(o_upd), 1);
        cmp("rst_state", int'(o_state), 0);
        i_rst = 1'b0;
        cyc(1);
        i_ack = 1'b1; cyc(1); i_ack = 1'b0;
        cmp("ack_clears_upd", int'(o_upd), 0);

        // 2: three-cycle tap
        i_btn_up = 1'b1; cyc(1);
        cmp("tap_vol", int'(o_vol), 25);
        cmp("tap_upd", int'(o_upd), 1);
        cmp("tap_state", int'(o_state), 1);
        cyc(2); i_btn_up = 1'b0; cyc(1);
        cmp("tap_idle", int'(o_state), 0);
        cyc(3);
        cmp("tap_no_repeat", int'(o_vol), 25);

        // 3: hold and auto-repeat from 24
        cpu_set(24);
        i_btn_up = 1'b1; cyc(1);
        cmp("hold_t1", int'(o_vol), 25);
        cyc(7);
        cmp("hold_t8_state", int'(o_state), 1);
        cmp("hold_t8_vol", int'(o_vol), 25);
        cyc(1);
        cmp("hold_t9", int'(o_vol), 26);
        cmp("hold_t9_state", int'(o_state), 2);
        cyc(4);
        cmp("hold_t13", int'(o_vol), 27);
        cyc(4);
        cmp("hold_t17", int'(o_vol), 28);
        i_btn_up = 1'b0; cyc(2);

        // 4: saturation at both ends with continuous ack
        cpu_set(30);
        i_ack = 1'b1; i_btn_up = 1'b1; cyc(30); i_btn_up = 1'b0; cyc(2);
        cmp("sat_hi_vol", int'(o_vol), 31);
        cmp("sat_hi_upd", int'(o_upd), 0);
        i_ack = 1'b0;
        cpu_set(1);
        i_ack = 1'b1; i_btn_dn = 1'b1; cyc(30); i_btn_dn = 1'b0; cyc(2);
        cmp("sat_lo_vol", int'(o_vol), 0);
        cmp("sat_lo_upd", int'(o_upd), 0);
        i_ack = 1'b0;

        // 5: combo toggles mute once, then a dn tap unmutes
        cpu_set(10);
        i_btn_up = 1'b1; i_btn_dn = 1'b1; cyc(10);
        cmp("combo_mute", int'(o_mute), 1);
        cmp("combo_vol", int'(o_vol), 10);
        cmp("combo_state", int'(o_state), 3);
        i_btn_dn = 1'b0; cyc(5);
        cmp("combo_single_state", int'(o_state), 3);
        cmp("combo_single_vol", int'(o_vol), 10);
        i_btn_up = 1'b0; cyc(1);
        cmp("combo_exit", int'(o_state), 0);
        i_btn_dn = 1'b1; cyc(1); i_btn_dn = 1'b0;
        cmp("dn_tap_vol", int'(o_vol), 9);
        cmp("dn_tap_unmute", int'(o_mute), 0);
        cyc(2);

        // 6: CPU write beats step, then async reset mid-REPEAT
        i_set_valid = 1'b1; i_set_vol = VOL_W'(40); i_btn_up = 1'b1; cyc(1);
        i_set_valid = 1'b0;
        cmp("set_clamp_vol", int'(o_vol), 31);
        cmp("set_state", int'(o_state), 1);
        cyc(10);
        cmp("repeat_state", int'(o_state), 2);
        @(posedge i_clk); #2;
        i_rst = 1'b1; #1;
        cmp("async_rst_vol", int'(o_vol), 24);
        cmp("async_rst_upd", int'(o_upd), 1);
        cmp("async_rst_state", int'(o_state), 0);
        cyc(2); i_rst = 1'b0; cyc(5);
        cmp("held_after_rst_vol", int'(o_vol), 24);
        cmp("held_after_rst_state", int'(o_state), 0);
        i_btn_up = 1'b0; cyc(2);

        // Random traffic, checked cycle by cycle against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(15) == 0) i_btn_up = ~i_btn_up;
            if ($urandom_range(15) == 0) i_btn_dn = ~i_btn_dn;
            i_set_valid = ($urandom_range(29) == 0);
            i_set_vol   = VOL_W'($urandom_range(63));
            i_ack       = ($urandom_range(2) == 0);
            cyc(1);
        end
        i_set_valid = 1'b0; i_ack = 1'b0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
